// File: rtl/envelope_gen.sv
// envelope_gen: ADSR envelope generator producing an unsigned fixed-point
// gain (0..MAX, MAX = 1 << FIXED_POINT) for a downstream multiplier.
//
// Ports
//   clk_in         clock, rising edge
//   reset          synchronous, active-low reset
//   tick           sample strobe; the envelope only advances on tick cycles
//   gate           note held (1) / released (0); rising edges retrigger
//   attack_rate    level increment per tick in ATTACK (0 = jump to MAX)
//   decay_rate     level decrement per tick in DECAY (0 = jump to sustain)
//   sustain_level  sustain target, clamped to MAX
//   release_rate   level decrement per tick in RELEASE (0 = jump to 0)
//   env_level      registered gain
//   state          current state code (IDLE=0 .. RELEASE=4)
//   busy           high whenever state != IDLE
//   done           one-cycle pulse when RELEASE reaches 0 and returns to IDLE
module envelope_gen #(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick,
  input  logic               gate,
  input  logic [C_WIDTH-1:0] attack_rate,
  input  logic [C_WIDTH-1:0] decay_rate,
  input  logic [C_WIDTH-1:0] sustain_level,
  input  logic [C_WIDTH-1:0] release_rate,
  output logic [C_WIDTH-1:0] env_level,
  output logic [2:0]         state,
  output logic               busy,
  output logic               done
);

  localparam logic [C_WIDTH-1:0] MAX = {{(C_WIDTH-1){1'b0}}, 1'b1} << FIXED_POINT;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [C_WIDTH-1:0] level_q, level_d;
  logic               gate_q;
  logic               pend_q, pend_d;
  logic               done_q, done_d;
  logic [C_WIDTH-1:0] sus_lvl;
  logic [C_WIDTH-1:0] nxt_lvl;

  // min(a + b, MAX), evaluated one bit wider so a large rate cannot wrap.
  function automatic logic [C_WIDTH-1:0] sat_add_max(input logic [C_WIDTH-1:0] a,
                                                     input logic [C_WIDTH-1:0] b);
    logic [C_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, MAX}) ? MAX : s[C_WIDTH-1:0];
  endfunction

  // max(a - b, floor) without underflow.
  function automatic logic [C_WIDTH-1:0] sub_floor(input logic [C_WIDTH-1:0] a,
                                                   input logic [C_WIDTH-1:0] b,
                                                   input logic [C_WIDTH-1:0] floor);
    logic [C_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[C_WIDTH] || (d[C_WIDTH-1:0] <= floor)) ? floor : d[C_WIDTH-1:0];
  endfunction

  // State, level, gate history and retrigger flag
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Next state and next level
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    done_d  = 1'b0;
    nxt_lvl = '0;
    sus_lvl = (sustain_level > MAX) ? MAX : sustain_level;
    // A tick consumes any pending edge; an edge seen this cycle re-arms it
    // so it is honoured on the following tick.
    pend_d  = (tick ? 1'b0 : pend_q) | (gate & ~gate_q);

    if (state_q > RELEASE) begin
      state_d = IDLE;
      level_d = '0;
    end else if (tick) begin
      if (pend_q) begin
        // Retrigger keeps the current level so there is no click.
        state_d = ATTACK;
      end else if (!gate && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
        state_d = RELEASE;
      end else begin
        case (state_q)
          ATTACK: begin
            nxt_lvl = (attack_rate == '0) ? MAX : sat_add_max(level_q, attack_rate);
            level_d = nxt_lvl;
            if (nxt_lvl == MAX) state_d = DECAY;
          end
          DECAY: begin
            nxt_lvl = (decay_rate == '0) ? sus_lvl : sub_floor(level_q, decay_rate, sus_lvl);
            level_d = nxt_lvl;
            if (nxt_lvl == sus_lvl) state_d = SUSTAIN;
          end
          SUSTAIN: level_d = sus_lvl;
          RELEASE: begin
            nxt_lvl = (release_rate == '0) ? '0 : sub_floor(level_q, release_rate, '0);
            level_d = nxt_lvl;
            if (nxt_lvl == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
          default: level_d = '0;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    state     = state_q;
    env_level = level_q;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule

// File: tb/tb_envelope_gen.sv
// Bench for envelope_gen: C_WIDTH=32, FIXED_POINT=8 (MAX=256), tick every
// 4 clocks. Expected per-tick results are queued by the stimulus and checked
// by a monitor just after each tick edge.
module tb_envelope_gen;

  localparam int W = 32;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b0;
  logic         tick   = 1'b0;
  logic         gate   = 1'b0;
  logic [W-1:0] attack_rate   = '0;
  logic [W-1:0] decay_rate    = '0;
  logic [W-1:0] sustain_level = '0;
  logic [W-1:0] release_rate  = '0;
  logic [W-1:0] env_level;
  logic [2:0]   state;
  logic         busy;
  logic         done;

  typedef struct {
    string        tag;
    logic [W-1:0] lvl;
    logic [2:0]   st;
    logic         dn;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] last_lvl = '0;

  envelope_gen #(.C_WIDTH(32), .FIXED_POINT(8)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .tick          (tick),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .env_level     (env_level),
    .state         (state),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tick strobe: one cycle high in every four.
  initial begin
    forever begin
      repeat (3) @(posedge clk_in);
      #1 tick = 1'b1;
      @(posedge clk_in);
      #1 tick = 1'b0;
    end
  end

  // Monitor: after every tick edge out of reset, pop one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      if (tick && reset && sb.size() > 0) begin
        #2;
        e = sb.pop_front();
        chk({e.tag, "_lvl"},   env_level,   e.lvl);
        chk({e.tag, "_state"}, 32'(state),  32'(e.st));
        chk({e.tag, "_busy"},  32'(busy),   32'(e.st != S_IDLE));
        chk({e.tag, "_done"},  32'(done),   32'(e.dn));
        last_lvl = e.lvl;
      end
    end
  end

  task automatic expect_tick(input string tag, input logic [W-1:0] lvl,
                             input logic [2:0] st, input logic dn);
    exp_t e;
    e.tag = tag;
    e.lvl = lvl;
    e.st  = st;
    e.dn  = dn;
    sb.push_back(e);
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk_in);
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Level must not move on a non-tick edge.
  task automatic check_hold(input string tag);
    @(posedge clk_in);
    #2;
    chk(tag, env_level, last_lvl);
    @(negedge clk_in);
  endtask

  // done must drop one clock after its pulse.
  task automatic done_end(input string tag);
    @(posedge clk_in);
    #2;
    chk(tag, 32'(done), 32'd0);
    @(negedge clk_in);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in);
      if (tick) break;
    end
    @(negedge clk_in);
  endtask

  // Raise gate and let the edge register before the next tick.
  task automatic gate_rise();
    gate = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_lvl",   env_level,  32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    reset = 1'b1;
    @(negedge clk_in);

    // Full envelope
    attack_rate = 64; decay_rate = 32; sustain_level = 128; release_rate = 100;
    gate_rise();
    expect_tick("full_trig", 0,   S_ATK, 1'b0);
    expect_tick("full_a1",   64,  S_ATK, 1'b0);
    check_hold("full_hold_a1");
    expect_tick("full_a2",   128, S_ATK, 1'b0);
    expect_tick("full_a3",   192, S_ATK, 1'b0);
    expect_tick("full_a4",   256, S_DEC, 1'b0);
    check_hold("full_hold_a4");
    expect_tick("full_d1",   224, S_DEC, 1'b0);
    expect_tick("full_d2",   192, S_DEC, 1'b0);
    expect_tick("full_d3",   160, S_DEC, 1'b0);
    expect_tick("full_d4",   128, S_SUS, 1'b0);
    expect_tick("full_s1",   128, S_SUS, 1'b0);
    gate = 1'b0;
    expect_tick("full_rel",  128, S_REL, 1'b0);
    expect_tick("full_r1",   28,  S_REL, 1'b0);
    check_hold("full_hold_r1");
    expect_tick("full_r2",   0,   S_IDLE, 1'b1);
    done_end("full_done_end");

    // Zero rates, sustain tracking
    attack_rate = 0; decay_rate = 0; sustain_level = 100; release_rate = 0;
    gate_rise();
    expect_tick("zero_trig", 0,   S_ATK, 1'b0);
    expect_tick("zero_a",    256, S_DEC, 1'b0);
    expect_tick("zero_d",    100, S_SUS, 1'b0);
    sustain_level = 200;
    expect_tick("zero_strk", 200, S_SUS, 1'b0);
    gate = 1'b0;
    expect_tick("zero_rel",  200, S_REL, 1'b0);
    expect_tick("zero_r",    0,   S_IDLE, 1'b1);
    done_end("zero_done_end");

    // Saturation of huge rates
    attack_rate = 10; decay_rate = 0; sustain_level = 128; release_rate = 32'hFFFF_FFFF;
    gate_rise();
    expect_tick("sat_trig",  0,   S_ATK, 1'b0);
    expect_tick("sat_a10",   10,  S_ATK, 1'b0);
    attack_rate = 32'hFFFF_FFFF;
    expect_tick("sat_amax",  256, S_DEC, 1'b0);
    expect_tick("sat_d",     128, S_SUS, 1'b0);
    gate = 1'b0;
    expect_tick("sat_rel",   128, S_REL, 1'b0);
    expect_tick("sat_r",     0,   S_IDLE, 1'b1);
    done_end("sat_done_end");

    // Retrigger from RELEASE
    attack_rate = 64; decay_rate = 0; sustain_level = 128; release_rate = 68;
    gate_rise();
    expect_tick("rt_trig",   0,   S_ATK, 1'b0);
    expect_tick("rt_a1",     64,  S_ATK, 1'b0);
    expect_tick("rt_a2",     128, S_ATK, 1'b0);
    expect_tick("rt_a3",     192, S_ATK, 1'b0);
    expect_tick("rt_a4",     256, S_DEC, 1'b0);
    expect_tick("rt_d",      128, S_SUS, 1'b0);
    gate = 1'b0;
    expect_tick("rt_rel",    128, S_REL, 1'b0);
    expect_tick("rt_r1",     60,  S_REL, 1'b0);
    gate_rise();
    expect_tick("rt_re1",    60,  S_ATK, 1'b0);
    expect_tick("rt_re1_a",  124, S_ATK, 1'b0);
    gate = 1'b0;
    expect_tick("rt_rel2",   124, S_REL, 1'b0);
    expect_tick("rt_r2",     56,  S_REL, 1'b0);
    gate_rise();
    gate = 1'b0;
    expect_tick("rt_pulse",  56,  S_ATK, 1'b0);
    expect_tick("rt_p_rel",  56,  S_REL, 1'b0);
    expect_tick("rt_p_r",    0,   S_IDLE, 1'b1);
    done_end("rt_done_end");

    // Reset mid-ATTACK, then a clamped sustain above MAX
    attack_rate = 64; decay_rate = 32; sustain_level = 32'h1000; release_rate = 0;
    gate_rise();
    expect_tick("mr_trig",   0,   S_ATK, 1'b0);
    expect_tick("mr_a1",     64,  S_ATK, 1'b0);
    expect_tick("mr_a2",     128, S_ATK, 1'b0);
    expect_tick("mr_a3",     192, S_ATK, 1'b0);
    reset = 1'b0;
    @(posedge clk_in);
    #2;
    chk("mr_rst_lvl",   env_level,  32'd0);
    chk("mr_rst_state", 32'(state), 32'd0);
    chk("mr_rst_busy",  32'(busy),  32'd0);
    chk("mr_rst_done",  32'(done),  32'd0);
    repeat (6) @(negedge clk_in);
    chk("mr_hold_state", 32'(state), 32'd0);
    chk("mr_hold_lvl",   env_level,  32'd0);
    gate = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    last_lvl = '0;
    wait_tick();
    chk("mr_idle_state", 32'(state), 32'd0);
    gate_rise();
    expect_tick("big_trig",  0,   S_ATK, 1'b0);
    expect_tick("big_a1",    64,  S_ATK, 1'b0);
    expect_tick("big_a2",    128, S_ATK, 1'b0);
    expect_tick("big_a3",    192, S_ATK, 1'b0);
    expect_tick("big_a4",    256, S_DEC, 1'b0);
    expect_tick("big_d",     256, S_SUS, 1'b0);
    expect_tick("big_s",     256, S_SUS, 1'b0);
    gate = 1'b0;
    expect_tick("big_rel",   256, S_REL, 1'b0);
    expect_tick("big_r",     0,   S_IDLE, 1'b1);
    done_end("big_done_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
REQ-001 The module SHALL have parameter C_WIDTH, default 32, the width of all level and rate values.
REQ-002 The module SHALL have parameter FIXED_POINT, default 8, the number of fraction bits; unity gain MAX = 1 << FIXED_POINT.
REQ-003 The module SHALL have port clk_in  input  1  clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port tick  input  1  sample strobe; level advances only on cycles with tick=1.
REQ-006 The module SHALL have port gate  input  1  note held (1) or released (0).
REQ-007 The module SHALL have port attack_rate  input  C_WIDTH  level increment per tick in ATTACK.
REQ-008 The module SHALL have port decay_rate  input  C_WIDTH  level decrement per tick in DECAY.
REQ-009 The module SHALL have port sustain_level  input  C_WIDTH  sustain target, clamped to MAX.
REQ-010 The module SHALL have port release_rate  input  C_WIDTH  level decrement per tick in RELEASE.
REQ-011 The module SHALL have port env_level  output  C_WIDTH  registered gain, unsigned fixed point, range 0..MAX, for the multiplier b operand.
REQ-012 The module SHALL have port state  output  3  current state code.
REQ-013 The module SHALL have port busy  output  1  high when state != IDLE.
REQ-014 The module SHALL have port done  output  1  one-cycle pulse on the RELEASE->IDLE transition.

Function
REQ-015 States SHALL be IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 SHALL return to IDLE on the next clock with env_level=0.
REQ-016 gate SHALL be registered every clk_in cycle; rising edge (gate & ~gate_d) SHALL set a pending flag, held until consumed by a tick cycle.
REQ-017 On a tick cycle with pending set: state -> ATTACK from any state, pending cleared, env_level unchanged (retrigger continues from current level).
REQ-018 Otherwise, on a tick cycle with gate=0 and state in ATTACK/DECAY/SUSTAIN: state -> RELEASE, env_level unchanged that tick.
REQ-019 ATTACK per tick: env_level = min(env_level + attack_rate, MAX), computed C_WIDTH+1 bits wide (no wrap); on reaching MAX -> DECAY.
REQ-020 DECAY per tick: env_level = max(env_level - decay_rate, S), S = min(sustain_level, MAX), no underflow; on reaching S -> SUSTAIN.
REQ-021 SUSTAIN per tick: env_level = S (tracks sustain_level changes).
REQ-022 RELEASE per tick: env_level = env_level > release_rate ? env_level - release_rate : 0; on reaching 0 -> IDLE and done=1 for that one clock.
REQ-023 A rate of 0 SHALL mean instantaneous: ATTACK jumps to MAX, DECAY to S, RELEASE to 0, in one tick.
REQ-024 Latency: state and env_level SHALL update on the clock edge ending the tick cycle; no change on non-tick cycles.
REQ-025 Rising edge and gate low in same tick window: retrigger (REQ-017) wins; release follows on the next tick if gate still 0.
REQ-026 If S reached mid-ATTACK, ATTACK SHALL still continue to MAX before DECAY.
REQ-027 IDLE SHALL hold env_level=0 and ignore gate level; only pending edges leave IDLE.

Reset
REQ-028 When reset=0 at a clock edge: state=IDLE, env_level=0, busy=0, done=0, pending=0, gate_d=0, regardless of state (including mid-operation); tick ignored.
REQ-029 The first rising edge of gate after reset release SHALL be detected (gate_d reset to 0).

Verification (C_WIDTH=32, FIXED_POINT=8, MAX=256, tick every 4 clocks)
REQ-030 Full envelope: attack=64, decay=32, sustain=128, release=100, gate high -> env_level 64,128,192,256 (DECAY),224,192,160,128 (SUSTAIN); gate low -> 128 (RELEASE),28,0 with done one clock, busy=0.
REQ-031 Zero rates: attack=0, decay=0, sustain=100, gate high -> 256 then 100 in two ticks; gate low with release=0 -> 0/IDLE on second tick.
REQ-032 Saturation: attack=0xFFFFFFFF from level 10 -> 256, no wrap; release=0xFFFFFFFF from 128 -> 0.
REQ-033 Retrigger: release=68 from 128 gives 60, gate pulses high 1 clock between ticks -> ATTACK at next tick from 60, then 124 with attack=64; next tick gate=0 -> RELEASE.
REQ-034 Reset mid-ATTACK at level 192 -> next clock env_level=0, state=0, busy=0, no done pulse; gate held high -> stays IDLE until new rising edge.
REQ-035 sustain_level=0x1000 (>MAX) -> DECAY exits immediately at 256, SUSTAIN holds 256.
